// File: rtl/alu_ctrl.sv
// alu_ctrl: command sequencer that feeds the ALU from a small register file and returns results
module alu_ctrl #(
  parameter int NREG = 4,
  parameter int W = 8
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [3:0]              cmd_op,
  input  logic [$clog2(NREG)-1:0] cmd_rd,
  input  logic [$clog2(NREG)-1:0] cmd_ra,
  input  logic [$clog2(NREG)-1:0] cmd_rb,
  input  logic                    cmd_imm_en,
  input  logic [W-1:0]            cmd_imm,
  output logic [W-1:0]            alu_a,
  output logic [W-1:0]            alu_b,
  output logic [3:0]              alu_s,
  input  logic [W-1:0]            alu_r,
  input  logic                    alu_c,
  input  logic                    alu_v,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [W-1:0]            rsp_data,
  output logic                    rsp_c,
  output logic                    rsp_v,
  output logic                    rsp_err
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t state;
  logic [W-1:0] rf [NREG];
  logic [$clog2(NREG)-1:0] rd;
  logic alu_op, ldi;
  assign alu_op = cmd_op inside {4'b1110, 4'b1101, 4'b1100, 4'b1011, 4'b1010, 4'b1001, 4'b1000, 4'b0111};
  assign ldi = cmd_op == 4'b0000;
  assign cmd_ready = state == IDLE;
  assign rsp_valid = state == RESP;
  // alu_s only ever takes a legal select; LDI and illegal codes leave it parked at MOV
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
      rd <= '0;
      alu_a <= '0;
      alu_b <= '0;
      alu_s <= 4'b1000;
      rsp_data <= '0;
      rsp_c <= 1'b0;
      rsp_v <= 1'b0;
      rsp_err <= 1'b0;
    end else begin
      case (state)
        IDLE: if (cmd_valid) begin
          alu_a <= rf[cmd_ra];
          alu_b <= cmd_imm_en ? cmd_imm : rf[cmd_rb];
          alu_s <= alu_op ? cmd_op : 4'b1000;
          rd <= cmd_rd;
          rsp_data <= ldi ? cmd_imm : '0;
          rsp_c <= 1'b0;
          rsp_v <= 1'b0;
          rsp_err <= !alu_op && !ldi;
          if (ldi) rf[cmd_rd] <= cmd_imm;
          state <= alu_op ? EXEC : RESP;
        end
        EXEC: begin
          rf[rd] <= alu_r;
          rsp_data <= alu_r;
          rsp_c <= alu_c;
          rsp_v <= alu_v;
          rsp_err <= 1'b0;
          alu_s <= 4'b1000;
          state <= RESP;
        end
        RESP: if (rsp_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
